// File: rtl/instr_mem_responder.sv
// Instruction memory responder: queues fetch requests and answers them
// in order from a word-addressed RAM with a fixed access latency.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module instr_mem_responder #(
    parameter int MEM_WORDS  = 1024,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         sys_clk,
    input  logic                         reset,
    input  logic                         fetch_req,
    input  logic [`ADDR_WIDTH-1:0]       fetch_req_addr,
    output logic                         fetch_req_ready,
    input  logic                         flush,
    output logic                         fetched_valid,
    output logic [31:0]                  fetched_instr,
    output logic [`ADDR_WIDTH-1:0]       fetched_instr_addr,
    output logic                         fetched_err,
    input  logic                         mem_we,
    input  logic [$clog2(MEM_WORDS)-1:0] mem_waddr,
    input  logic [31:0]                  mem_wdata
);
    localparam int AW = `ADDR_WIDTH;
    localparam int IW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic {
        IDLE,
        WAIT
    } state_e;

    logic [31:0]   mem_q  [MEM_WORDS];
    logic [AW-1:0] fifo_q [FIFO_DEPTH];

    logic [PW:0]   wr_ptr_q, wr_ptr_d;
    logic [PW:0]   rd_ptr_q, rd_ptr_d;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          valid_q, valid_d;
    logic [31:0]   instr_q, instr_d;
    logic [AW-1:0] resp_addr_q, resp_addr_d;
    logic          err_q, err_d;

    logic          empty, full, push, pop, resp;
    logic [AW-1:0] word_idx;
    logic          lookup_err;
    logic [31:0]   lookup_data;

    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
        fetch_req_ready = !reset && !full;
        push = fetch_req && fetch_req_ready;

        pop     = 1'b0;
        resp    = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;

        unique case (state_q)
            IDLE: pop = !empty;
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    resp    = 1'b1;
                    pop     = !empty;
                    state_d = empty ? IDLE : WAIT;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            addr_d  = fifo_q[rd_ptr_q[PW-1:0]];
            cnt_d   = CW'(LATENCY - 1);
            state_d = WAIT;
        end

        wr_ptr_d = wr_ptr_q + (PW+1)'(push);
        rd_ptr_d = rd_ptr_q + (PW+1)'(pop);

        // Lookup uses the pre-edge RAM, so a same-edge write returns old data
        word_idx    = {2'b00, addr_q[AW-1:2]};
        lookup_err  = (addr_q[1:0] != 2'b00) ||
                      (word_idx >= AW'(MEM_WORDS));
        lookup_data = lookup_err ? 32'h0 : mem_q[addr_q[IW+1:2]];

        valid_d     = resp && !flush;
        instr_d     = instr_q;
        resp_addr_d = resp_addr_q;
        err_d       = err_q;
        if (valid_d) begin
            instr_d     = lookup_data;
            resp_addr_d = addr_q;
            err_d       = lookup_err;
        end

        // Flush keeps only a request pushed on this same edge
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            state_d  = IDLE;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            valid_q     <= 1'b0;
            instr_q     <= '0;
            resp_addr_q <= '0;
            err_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            valid_q     <= valid_d;
            instr_q     <= instr_d;
            resp_addr_q <= resp_addr_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push) fifo_q[wr_ptr_q[PW-1:0]] <= fetch_req_addr;
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign fetched_valid      = valid_q;
    assign fetched_instr      = instr_q;
    assign fetched_instr_addr = resp_addr_q;
    assign fetched_err        = err_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: directed scenarios plus random traffic
// scored against a queue-based timing/data model.
module tb_instr_mem_responder;
    localparam int MW    = 1024;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_req_addr = '0;
    logic        fetch_req_ready;
    logic        flush = 1'b0;
    logic        fetched_valid;
    logic [31:0] fetched_instr;
    logic [31:0] fetched_instr_addr;
    logic        fetched_err;
    logic        mem_we = 1'b0;
    logic [9:0]  mem_waddr = '0;
    logic [31:0] mem_wdata = '0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [31:0] ref_mem [MW];
    exp_t        exp_q[$];
    exp_t        resp_log[$];
    int          acc_log[$];
    logic [31:0] req_list[$];
    int          last_resp = -1000;
    int          fl_k, rst_k, we_k;
    logic [9:0]  we_a;
    logic [31:0] we_d;
    bit          ready_low;

    instr_mem_responder #(
        .MEM_WORDS(MW), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .sys_clk(clk),
        .reset(reset),
        .fetch_req(fetch_req),
        .fetch_req_addr(fetch_req_addr),
        .fetch_req_ready(fetch_req_ready),
        .flush(flush),
        .fetched_valid(fetched_valid),
        .fetched_instr(fetched_instr),
        .fetched_instr_addr(fetched_instr_addr),
        .fetched_err(fetched_err),
        .mem_we(mem_we),
        .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Response time: never earlier than accept+LAT+2, never closer than LAT
    task automatic model_accept(input logic [31:0] a, input int c);
        exp_t e;
        int   w;
        w = int'(a >> 2);
        e.addr  = a;
        e.err   = (a[1:0] != 2'b00) || (w >= MW);
        e.instr = e.err ? 32'h0 : ref_mem[w];
        e.cyc   = (c + LAT + 2 > last_resp + LAT) ? c + LAT + 2 : last_resp + LAT;
        last_resp = e.cyc;
        exp_q.push_back(e);
        acc_log.push_back(c);
    endtask

    task automatic setup();
        req_list.delete();
        resp_log.delete();
        acc_log.delete();
        fl_k = -1;
        rst_k = -1;
        we_k = -1;
        ready_low = 0;
    endtask

    task automatic run(input string name, input int ncyc,
                       input int req_pct, input int flush_pct);
        bit   pres;
        bit   rst_now, fl_now, er;
        int   occ;
        exp_t e;
        pres = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (fetched_valid) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL %s spurious: addr=%h cyc=%0d", name,
                             fetched_instr_addr, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (fetched_instr_addr !== e.addr || fetched_instr !== e.instr ||
                        fetched_err !== e.err || cyc != e.cyc) begin
                        fails++;
                        $display("FAIL %s resp: got a=%h i=%h e=%b c=%0d want a=%h i=%h e=%b c=%0d",
                                 name, fetched_instr_addr, fetched_instr, fetched_err, cyc,
                                 e.addr, e.instr, e.err, e.cyc);
                    end
                end
                resp_log.push_back('{fetched_instr_addr, fetched_instr, fetched_err, cyc});
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                tests++;
                fails++;
                e = exp_q.pop_front();
                $display("FAIL %s missing: addr=%h due=%0d now=%0d", name, e.addr, e.cyc, cyc);
            end

            rst_now = (k == rst_k);
            fl_now  = (k == fl_k) || ($urandom_range(99) < flush_pct);
            if (!pres && req_list.size() != 0 && $urandom_range(99) < req_pct) pres = 1;
            reset          = rst_now;
            flush          = fl_now;
            fetch_req      = pres;
            fetch_req_addr = pres ? req_list[0] : 32'h0;
            mem_we         = (k == we_k);
            mem_waddr      = we_a;
            mem_wdata      = we_d;
            #1;

            occ = 0;
            foreach (exp_q[i]) if (exp_q[i].cyc - LAT - 1 >= cyc) occ++;
            er = !rst_now && (occ < DEPTH);
            tests++;
            if (fetch_req_ready !== er) begin
                fails++;
                $display("FAIL %s ready: got %b want %b cyc=%0d", name, fetch_req_ready, er, cyc);
            end
            if (!er) ready_low = 1;
            if (rst_now || fl_now) begin
                exp_q.delete();
                last_resp = -1000;
            end
            if (pres && er) begin
                model_accept(req_list.pop_front(), cyc);
                pres = 0;
            end
            if (mem_we) ref_mem[mem_waddr] = mem_wdata;
        end
        @(negedge clk);
        fetch_req = 1'b0;
        flush     = 1'b0;
        reset     = 1'b0;
        mem_we    = 1'b0;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s leftover: got %0d pending want 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (fetched_valid !== 1'b0 || fetched_instr !== 32'h0 ||
            fetched_instr_addr !== 32'h0 || fetched_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b i=%h a=%h e=%b want all 0",
                     fetched_valid, fetched_instr, fetched_instr_addr, fetched_err);
        end
        tests++;
        if (fetch_req_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready: got %b want 0", fetch_req_ready);
        end
        reset = 1'b0;
        #1;
        tests++;
        if (fetch_req_ready !== 1'b1) begin
            fails++;
            $display("FAIL post_reset_ready: got %b want 1", fetch_req_ready);
        end
        for (int i = 0; i < MW; i++) begin
            @(negedge clk);
            mem_we     = 1'b1;
            mem_waddr  = 10'(i);
            mem_wdata  = (i < 4) ? 32'h13 + 32'(i) * 32'h80 : $urandom;
            ref_mem[i] = mem_wdata;
        end
        @(negedge clk);
        mem_we = 1'b0;
    endtask

    task automatic test_single();
        setup();
        req_list.push_back(32'h8);
        run("single", 12, 100, 0);
        tests++;
        if (resp_log.size() != 1 || acc_log.size() != 1 ||
            resp_log[0].cyc - acc_log[0] != 4 || resp_log[0].instr !== 32'h113 ||
            resp_log[0].addr !== 32'h8 || resp_log[0].err !== 1'b0) begin
            fails++;
            $display("FAIL single: got %0d resps instr=%h want 1 resp at T+4 instr=00000113",
                     resp_log.size(), resp_log.size() ? resp_log[0].instr : 32'h0);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        setup();
        for (int i = 0; i < 10; i++) req_list.push_back(32'(i * 4));
        run("b2b", 40, 100, 0);
        ok = (resp_log.size() == 10);
        for (int i = 0; ok && i < 10; i++) begin
            if (resp_log[i].addr !== 32'(i * 4)) ok = 0;
            if (i > 0 && resp_log[i].cyc - resp_log[i-1].cyc != 2) ok = 0;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL b2b_order: got %0d resps want 10 in order 2 cycles apart",
                     resp_log.size());
        end
        tests++;
        if (!ready_low) begin
            fails++;
            $display("FAIL b2b_full: ready never dropped, want low at 4 entries");
        end
    endtask

    task automatic test_errors();
        setup();
        req_list.push_back(32'h6);
        req_list.push_back(32'(4 * MW));
        run("err", 16, 100, 0);
        tests++;
        if (resp_log.size() != 2 || resp_log[0].err !== 1'b1 || resp_log[0].instr !== 32'h0 ||
            resp_log[1].err !== 1'b1 || resp_log[1].instr !== 32'h0 ||
            resp_log[1].addr !== 32'(4 * MW)) begin
            fails++;
            $display("FAIL err: got %0d resps want 2 with err=1 instr=0", resp_log.size());
        end
    endtask

    task automatic test_flush();
        setup();
        req_list = '{32'h100, 32'h104, 32'h108, 32'h40};
        fl_k = 3;
        run("flush", 20, 100, 0);
        tests++;
        if (resp_log.size() != 1 || resp_log[0].addr !== 32'h40) begin
            fails++;
            $display("FAIL flush: got %0d resps first=%h want 1 resp addr=00000040",
                     resp_log.size(), resp_log.size() ? resp_log[0].addr : 32'h0);
        end
    endtask

    task automatic test_reset_mid();
        setup();
        req_list = '{32'h200, 32'h204, 32'h208};
        rst_k = 3;
        run("rst_mid", 16, 100, 0);
        tests++;
        if (resp_log.size() != 0 || fetched_valid !== 1'b0 || fetched_instr !== 32'h0 ||
            fetched_instr_addr !== 32'h0 || fetched_err !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid: got %0d resps i=%h a=%h want 0 resps and zero outputs",
                     resp_log.size(), fetched_instr, fetched_instr_addr);
        end
        setup();
        req_list.push_back(32'h8);
        run("rst_ram", 12, 100, 0);
        tests++;
        if (resp_log.size() != 1 || resp_log[0].instr !== 32'h113) begin
            fails++;
            $display("FAIL rst_ram: got %0d resps instr=%h want instr=00000113",
                     resp_log.size(), resp_log.size() ? resp_log[0].instr : 32'h0);
        end
    endtask

    task automatic test_write_race();
        setup();
        req_list.push_back(32'h8);
        we_k = 3;
        we_a = 10'd2;
        we_d = 32'hDEAD;
        run("wr_old", 12, 100, 0);
        tests++;
        if (resp_log.size() != 1 || resp_log[0].instr !== 32'h113) begin
            fails++;
            $display("FAIL wr_old: got instr=%h want 00000113",
                     resp_log.size() ? resp_log[0].instr : 32'h0);
        end
        setup();
        req_list.push_back(32'h8);
        run("wr_new", 12, 100, 0);
        tests++;
        if (resp_log.size() != 1 || resp_log[0].instr !== 32'hDEAD) begin
            fails++;
            $display("FAIL wr_new: got instr=%h want 0000dead",
                     resp_log.size() ? resp_log[0].instr : 32'h0);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        setup();
        for (int i = 0; i < 80; i++) begin
            a = 32'($urandom_range(MW + 16)) << 2;
            if ($urandom_range(7) == 0) a[1:0] = 2'($urandom_range(3));
            req_list.push_back(a);
        end
        run("random", 500, 60, 4);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_errors();
        test_flush();
        test_reset_mid();
        test_write_race();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
